// File: rtl/regfile_pkg.sv
// Shared types for the multiport register file: dump FSM states and packed-port slice helper.
package regfile_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } dump_state_e;

   // Low bit of port `port` in a bus packing fixed-width fields side by side.
   function automatic int unsigned slice_lo(input int unsigned port, input int unsigned w);
      return port * w;
   endfunction

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: walks addresses 0..DEPTH-1 over a valid/ready channel, then pulses done.
// Issues a capture strobe and address; the parent performs the array read with bypass.
module regfile_dump_ctrl
   import regfile_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int NB    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          dump_start,
   input  logic          dump_ready,
   output logic          dump_valid,
   output logic          dump_busy,
   output logic          dump_done,
   output logic [NB-1:0] dump_addr,
   output logic          cap_vld,
   output logic [NB-1:0] cap_addr
);

   localparam logic [NB-1:0] LAST = NB'(DEPTH - 1);

   dump_state_e   state_q, state_d;
   logic [NB-1:0] idx_q, idx_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      cap_vld  = 1'b0;
      cap_addr = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (dump_start) begin
               state_d  = ST_SEND;
               idx_d    = '0;
               valid_d  = 1'b1;
               busy_d   = 1'b1;
               cap_vld  = 1'b1;
               cap_addr = '0;
            end
         end
         ST_SEND: begin
            if (dump_ready) begin
               if (idx_q == LAST) begin
                  state_d = ST_DONE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  // Next word is captured on the accepting edge so valid never drops.
                  idx_d    = idx_q + 1'b1;
                  cap_vld  = 1'b1;
                  cap_addr = idx_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign dump_valid = valid_q;
   assign dump_busy  = busy_q;
   assign dump_done  = done_q;
   assign dump_addr  = idx_q;

endmodule

// File: rtl/regfile_multiport_dump.sv
// MIPS GPR file: N_READ registered write-first read ports, optional hardwired-zero r0,
// and a valid/ready dump channel streaming every register to the debug unit.
module regfile_multiport_dump
   import regfile_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int NB       = $clog2(DEPTH),
   parameter int N_READ   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [N_READ*NB-1:0]    read_register,
   output logic [N_READ*WIDTH-1:0] read_data,
   input  logic                    RegWrite,
   input  logic [NB-1:0]           write_register,
   input  logic [WIDTH-1:0]        write_data,
   input  logic                    dump_start,
   output logic                    dump_valid,
   input  logic                    dump_ready,
   output logic [NB-1:0]           dump_addr,
   output logic [WIDTH-1:0]        dump_data,
   output logic                    dump_busy,
   output logic                    dump_done
);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [WIDTH-1:0] dump_data_q, dump_data_d;
   logic             cap_vld;
   logic [NB-1:0]    cap_addr;

   // Value a read at `a` sees this edge: r0 pinned to zero, otherwise write-first.
   function automatic logic [WIDTH-1:0] rd_value(input logic [NB-1:0] a);
      if (ZERO_REG != 0 && a == '0)
         return '0;
      if (RegWrite && write_register == a)
         return write_data;
      return regs_q[a];
   endfunction

   always_comb begin
      regs_d = regs_q;
      if (RegWrite && !(ZERO_REG != 0 && write_register == '0))
         regs_d[write_register] = write_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         regs_q <= '{default: '0};
      else
         regs_q <= regs_d;
   end

   for (genvar k = 0; k < N_READ; k++) begin : g_rd
      logic [WIDTH-1:0] rdat_q, rdat_d;
      logic [NB-1:0]    raddr;

      assign raddr = read_register[slice_lo(k, NB) +: NB];

      always_comb begin
         rdat_d = rdat_q;
         if (enable)
            rdat_d = rd_value(raddr);
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset)
            rdat_q <= '0;
         else
            rdat_q <= rdat_d;
      end

      assign read_data[slice_lo(k, WIDTH) +: WIDTH] = rdat_q;
   end

   regfile_dump_ctrl #(
      .DEPTH (DEPTH),
      .NB    (NB)
   ) u_dump_ctrl (
      .clk        (clk),
      .reset      (reset),
      .dump_start (dump_start),
      .dump_ready (dump_ready),
      .dump_valid (dump_valid),
      .dump_busy  (dump_busy),
      .dump_done  (dump_done),
      .dump_addr  (dump_addr),
      .cap_vld    (cap_vld),
      .cap_addr   (cap_addr)
   );

   // Captured copy, so writes to the held address do not disturb a presented word.
   always_comb begin
      dump_data_d = dump_data_q;
      if (cap_vld)
         dump_data_d = rd_value(cap_addr);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         dump_data_q <= '0;
      else
         dump_data_q <= dump_data_d;
   end

   assign dump_data = dump_data_q;

endmodule

// File: tb/tb_regfile_multiport_dump.sv
// Randomized and directed bench for regfile_multiport_dump against a behavioural model.
module tb_regfile_multiport_dump;

   localparam int W  = 32;
   localparam int D  = 32;
   localparam int NB = 5;
   localparam int NR = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic           enable;
   logic [NR*NB-1:0] read_register;
   logic [NR*W-1:0]  read_data;
   logic           RegWrite;
   logic [NB-1:0]  write_register;
   logic [W-1:0]   write_data;
   logic           dump_start;
   logic           dump_valid;
   logic           dump_ready;
   logic [NB-1:0]  dump_addr;
   logic [W-1:0]   dump_data;
   logic           dump_busy;
   logic           dump_done;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int unsigned m_regs [D];
   int unsigned m_rd [NR];
   int          m_pos;      // -1 idle, 0..D-1 presenting word, D = done cycle
   int unsigned m_daddr;
   int unsigned m_ddata;

   always #5 clk = ~clk;

   regfile_multiport_dump #(
      .WIDTH(W), .DEPTH(D), .NB(NB), .N_READ(NR), .ZERO_REG(1)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .read_register  (read_register),
      .read_data      (read_data),
      .RegWrite       (RegWrite),
      .write_register (write_register),
      .write_data     (write_data),
      .dump_start     (dump_start),
      .dump_valid     (dump_valid),
      .dump_ready     (dump_ready),
      .dump_addr      (dump_addr),
      .dump_data      (dump_data),
      .dump_busy      (dump_busy),
      .dump_done      (dump_done)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned mval(input int unsigned a);
      if (a == 0) return 0;
      if (RegWrite && write_register == a) return write_data;
      return m_regs[a];
   endfunction

   function automatic void model_reset();
      foreach (m_regs[i]) m_regs[i] = 0;
      foreach (m_rd[k]) m_rd[k] = 0;
      m_pos = -1;
      m_daddr = 0;
      m_ddata = 0;
   endfunction

   function automatic void model_edge();
      if (enable)
         for (int k = 0; k < NR; k++)
            m_rd[k] = mval(read_register[k*NB +: NB]);
      if (m_pos == -1) begin
         if (dump_start) begin
            m_pos = 0; m_daddr = 0; m_ddata = mval(0);
         end
      end else if (m_pos == D) begin
         m_pos = -1;
      end else if (dump_ready) begin
         m_pos++;
         if (m_pos < D) begin
            m_daddr = m_pos; m_ddata = mval(m_pos);
         end
      end
      if (RegWrite && write_register != 0)
         m_regs[write_register] = write_data;
   endfunction

   task automatic check_outputs();
      for (int k = 0; k < NR; k++)
         chk($sformatf("rd%0d", k), read_data[k*W +: W], m_rd[k]);
      chk("dvalid", dump_valid, (m_pos >= 0 && m_pos < D));
      chk("dbusy", dump_busy, (m_pos >= 0));
      chk("ddone", dump_done, (m_pos == D));
      chk("daddr", dump_addr, m_daddr);
      chk("ddata", dump_data, m_ddata);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   // Reset raised between edges; outputs must clear without waiting for a clock.
   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      chk("rst_rd0", read_data[0 +: W], 0);
      chk("rst_rd1", read_data[W +: W], 0);
      chk("rst_dvalid", dump_valid, 0);
      chk("rst_dbusy", dump_busy, 0);
      model_reset();
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic set_rd(input int a0, input int a1);
      read_register = {NB'(a1), NB'(a0)};
   endtask

   task automatic wr(input int a, input int unsigned d);
      RegWrite = 1'b1; write_register = NB'(a); write_data = d;
   endtask

   task automatic finish_dump();
      int n = 0;
      dump_ready = 1'b1;
      while (dump_busy && n < 80) begin
         step();
         n++;
      end
      if (n >= 80) chk("dump_bound", 0, 1);
      step();
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; read_register = '0; RegWrite = 1'b0;
      write_register = '0; write_data = '0; dump_start = 1'b0; dump_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_outputs();
      reset = 1'b0;

      // 1: reset mid-cycle clears nonzero read data
      wr(3, 32'h0BAD_F00D); set_rd(3, 3); step();
      RegWrite = 1'b0; step();
      do_reset();
      set_rd(3, 17); step();
      chk("post_rst_rd", read_data[0 +: W], 0);

      // 2: plain write/read, r0 hardwired
      wr(5, 32'hDEAD_BEEF); step();
      RegWrite = 1'b0; set_rd(5, 5); step();
      chk("r5_p0", read_data[0 +: W], 32'hDEAD_BEEF);
      chk("r5_p1", read_data[W +: W], 32'hDEAD_BEEF);
      wr(0, 32'h1234); step();
      RegWrite = 1'b0; set_rd(0, 0); step();
      chk("r0_zero", read_data[0 +: W], 0);

      // 3: same-cycle bypass, then stall
      wr(7, 32'hA5A5_A5A5); set_rd(0, 7); step();
      chk("bypass", read_data[W +: W], 32'hA5A5_A5A5);
      enable = 1'b0; wr(7, 32'h1111_1111); set_rd(7, 5); step();
      chk("stall_hold", read_data[W +: W], 32'hA5A5_A5A5);
      RegWrite = 1'b0; enable = 1'b1; step();
      chk("stall_write", read_data[0 +: W], 32'h1111_1111);

      // 4: full dump under constant ready
      for (int i = 1; i < D; i++) begin
         wr(i, i * 3); step();
      end
      RegWrite = 1'b0; dump_ready = 1'b1; dump_start = 1'b1; step();
      dump_start = 1'b0;
      for (int i = 0; i < D; i++) begin
         chk("dump4_addr", dump_addr, i);
         chk("dump4_data", dump_data, i * 3);
         dump_start = (i == 10);
         step();
      end
      dump_start = 1'b0;
      chk("dump4_done33", dump_done, 1);
      step();
      chk("dump4_idle", dump_busy, 0);

      // 5: backpressure at addr 9
      dump_start = 1'b1; step();
      dump_start = 1'b0;
      repeat (9) step();
      dump_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) wr(9, 32'h55);
         else if (i == 2) wr(10, 32'h77);
         else RegWrite = 1'b0;
         step();
         chk("bp_addr", dump_addr, 9);
         chk("bp_data", dump_data, 27);
      end
      RegWrite = 1'b0; dump_ready = 1'b1; step();
      chk("bp_adv_addr", dump_addr, 10);
      chk("bp_adv_data", dump_data, 32'h77);
      finish_dump();

      // 6: reset aborts dump at addr 12
      dump_start = 1'b1; step();
      dump_start = 1'b0;
      repeat (12) step();
      chk("pre_abort_addr", dump_addr, 12);
      do_reset();
      repeat (3) begin
         step();
         chk("abort_nodone", dump_done, 0);
      end
      dump_start = 1'b1; step();
      dump_start = 1'b0;
      chk("restart_addr", dump_addr, 0);
      chk("restart_valid", dump_valid, 1);
      finish_dump();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         int unsigned wa;
         wa = $urandom_range(0, D - 1);
         RegWrite = ($urandom_range(0, 2) != 0);
         write_register = NB'(wa);
         write_data = $urandom;
         enable = ($urandom_range(0, 4) != 0);
         for (int k = 0; k < NR; k++)
            read_register[k*NB +: NB] = ($urandom_range(0, 3) == 0) ? NB'(wa) : NB'($urandom_range(0, D - 1));
         dump_start = ($urandom_range(0, 19) == 0);
         dump_ready = ($urandom_range(0, 9) < 7);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
